data_generation_lanes: RTL
==========================

// Module: data_generation_lanes
// PURPOSE
//  Parametrised successor of the single-lane note-position generator. It drives
//  NUM_LANES independent position counters, one per note lane of the game map.
//  Each lane advances by STEP on its own map tick, within [START, END].
//  Mode is WRAP (sawtooth) or BOUNCE (ping-pong), with a one-cycle wrap pulse.
//  Sits between the map/beat sequencer (tick source) and the lane renderers.
// PARAMETERS
//  NUM_LANES  4    number of independent lanes
//  DATA_W     8    width of each lane position value
//  START      100  lowest position; reset/restart value
//  STEP       4    increment per armed tick; legal range: 1 <= STEP <= END-START
//  END        116  highest legal position; END < 2**DATA_W
// PORTS
//  clk       in   1                 system clock; all state changes on posedge
//  reset     in   1                 reset; one clock; reset is synchronous and active-high
//  map       in   NUM_LANES         per-lane tick, 1-cycle pulse; bit i drives lane i
//  restart   in   1                 sync: all lanes to START, dir up; keeps data_en
//  mode      in   1                 0 = WRAP, 1 = BOUNCE; sampled on each tick
//  data_en   out  NUM_LANES         lane armed; set by first tick, sticky until reset
//  data      out  NUM_LANES*DATA_W  lane i position at [i*DATA_W +: DATA_W]
//  wrap      out  NUM_LANES         1-cycle pulse: lane wrapped (WRAP) or reversed (BOUNCE)
// BEHAVIOUR
//  - Reset (edge with reset=1): data_en=0, data[i]=START, dir[i]=up, wrap=0, all lanes.
//    Reset is checked only at the clock edge and has no asynchronous effect.
//  - Priority per edge: reset > restart > map tick > hold.
//  - restart=1: every lane gets data=START, dir=up, wrap=0.
//    If map[i] is also 1, data_en[i] <= 1, but no step is taken that edge.
//  - map[i]=1 with data_en[i]=0: data_en[i] <= 1; data[i] is unchanged (arming tick).
//  - map[i]=1 with data_en[i]=1 takes one step, 1-cycle latency:
//      WRAP  : nxt = data+STEP, computed in DATA_W+1 bits (no overflow).
//              If nxt > END: data <= START, wrap[i] <= 1. Else data <= nxt.
//      BOUNCE up  : if data+STEP > END: data <= data-STEP, dir <= down, wrap[i] <= 1;
//                   else data <= data+STEP.
//      BOUNCE down: if data < START+STEP: data <= data+STEP, dir <= up, wrap[i] <= 1;
//                   else data <= data-STEP.
//  - wrap[i] is 0 on every edge that does not reverse or wrap lane i. It is registered,
//    so it is high in the same cycle the new data value appears.
//  - map[i]=0: lane i holds data, dir and data_en.
//  - Lanes are fully independent. Any mix of map bits may be set in the same cycle.
//  - Mode switch mid-run takes effect on the next tick.
//    In WRAP, dir is ignored and forced to up on each WRAP step.
//  - map pulses wider than 1 cycle count as one tick per cycle high.
//  - Lane state is 2 regs/lane (data, dir) plus data_en bit.
//    Use a generate loop; no shared arithmetic between lanes.
// TESTING
//  1. Reset, mode=0, 6 single-cycle map[0] pulses.
//     -> data_en[0]=1 after pulse 1.
//     -> data[0]: 100,104,108,112,116,100.
//     -> wrap[0]=1 only with 116->100. Other lanes stay 100 with en=0.
//  2. mode=1, lane 1 armed, 10 ticks
//     -> 104,108,112,116,112,108,104,100,104,108.
//     -> wrap[1] pulses at 116->112 and 100->104.
//  3. map=4'b0101 each cycle x3 -> lanes 0,2 armed and at 104,108. Lanes 1,3: 100, en=0.
//  4. Lane 0 at 112, restart=1 with map[0]=1 -> data[0]=100, en=1, no step, wrap=0.
//     Next tick -> 104.
//  5. Lane 0 at 112, dir down in BOUNCE.
//     Assert reset between edges -> no change until next posedge.
//     Then data=100, en=0, dir=up, wrap=0.
//  6. Override STEP=5, WRAP -> 100,105,110,115,100.
//     Overshoot 120>116 wraps; wrap pulses once.

Source files
------------

// File: rtl/data_generation_lanes.sv
// NUM_LANES independent note-position counters. Each lane steps by STEP on its own map
// tick inside [START, END], either as a sawtooth (WRAP) or a ping-pong (BOUNCE).
module data_generation_lanes #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 8,
  parameter int START     = 100,
  parameter int STEP      = 4,
  parameter int END       = 116
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_LANES-1:0]          map,
  input  logic                          restart,
  input  logic                          mode,
  output logic [NUM_LANES-1:0]          data_en,
  output logic [NUM_LANES*DATA_W-1:0]   data,
  output logic [NUM_LANES-1:0]          wrap
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [DATA_W-1:0] START_D = DATA_W'(START);
  localparam logic [DATA_W-1:0] STEP_D  = DATA_W'(STEP);
  localparam logic [DATA_W:0]   STEP_X  = (DATA_W+1)'(STEP);
  localparam logic [DATA_W:0]   END_X   = (DATA_W+1)'(END);
  localparam logic [DATA_W:0]   LOW_X   = (DATA_W+1)'(START + STEP);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [DATA_W-1:0] pos, pos_nxt;
    dir_t              dir, dir_nxt;
    logic              en;
    logic              wrap_q, wrap_nxt;
    logic [DATA_W:0]   sum;

    // Extra bit on the sum so the END comparison can never be fooled by overflow.
    assign sum = {1'b0, pos} + STEP_X;

    // Next position/direction for one armed tick, evaluated in the current mode.
    always_comb begin
      pos_nxt  = pos;
      dir_nxt  = dir;
      wrap_nxt = 1'b0;
      if (!mode) begin
        dir_nxt = DIR_UP;
        if (sum > END_X) begin
          pos_nxt  = START_D;
          wrap_nxt = 1'b1;
        end else begin
          pos_nxt = sum[DATA_W-1:0];
        end
      end else if (dir == DIR_UP) begin
        if (sum > END_X) begin
          pos_nxt  = pos - STEP_D;
          dir_nxt  = DIR_DOWN;
          wrap_nxt = 1'b1;
        end else begin
          pos_nxt = sum[DATA_W-1:0];
        end
      end else begin
        if ({1'b0, pos} < LOW_X) begin
          pos_nxt  = sum[DATA_W-1:0];
          dir_nxt  = DIR_UP;
          wrap_nxt = 1'b1;
        end else begin
          pos_nxt = pos - STEP_D;
        end
      end
    end

    // The first tick on a lane only arms it; stepping begins on the following tick.
    always_ff @(posedge clk) begin
      if (reset) begin
        pos    <= START_D;
        dir    <= DIR_UP;
        en     <= 1'b0;
        wrap_q <= 1'b0;
      end else if (restart) begin
        pos    <= START_D;
        dir    <= DIR_UP;
        wrap_q <= 1'b0;
        if (map[i]) en <= 1'b1;
      end else if (map[i]) begin
        if (!en) begin
          en     <= 1'b1;
          wrap_q <= 1'b0;
        end else begin
          pos    <= pos_nxt;
          dir    <= dir_nxt;
          wrap_q <= wrap_nxt;
        end
      end else begin
        wrap_q <= 1'b0;
      end
    end

    assign data[i*DATA_W +: DATA_W] = pos;
    assign data_en[i]               = en;
    assign wrap[i]                  = wrap_q;
  end

endmodule
